// File: rtl/freq_autorange_ctrl.sv
// Gate/settle/evaluate sequencer for a frequency counter.
// It steps the measurement range up or down, with hysteresis, on over- and under-range results.
module freq_autorange_ctrl #(
  parameter int unsigned NUM_RANGES    = 8,
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned HYST          = 2,
  parameter int unsigned INIT_RANGE    = 0,
  localparam int unsigned RANGE_W      = $clog2(NUM_RANGES)
) (
  input  logic               clk_i,
  input  logic               clear_ni,
  input  logic               start_i,
  input  logic               cont_i,
  input  logic               hold_i,
  input  logic               cntover_i,
  input  logic               cntlow_i,
  output logic               reset_o,
  output logic               gate_o,
  output logic [RANGE_W-1:0] range_o,
  output logic [1:0]         std_f_sel_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               ovf_err_o,
  output logic               unf_err_o
);

  localparam int unsigned MaxCyc = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned HystW  = $clog2(HYST + 1);

  typedef enum logic [2:0] {StIdle, StRst, StGate, StSettle, StEval} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RANGE_W-1:0] range_q, range_d;
  logic [HystW-1:0]   up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic               cont_q, cont_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  logic               over, under, in_range;
  logic [HystW-1:0]   up_inc, dn_inc;
  logic               up_hit, dn_hit, can_up, can_dn;
  logic               ovf_set, unf_set;

  // Over wins when both flags are set.
  assign over     = cntover_i;
  assign under    = cntlow_i & ~cntover_i;
  assign in_range = ~cntover_i & ~cntlow_i;
  assign up_inc   = up_cnt_q + HystW'(1);
  assign dn_inc   = dn_cnt_q + HystW'(1);
  assign up_hit   = (up_inc == HystW'(HYST));
  assign dn_hit   = (dn_inc == HystW'(HYST));
  assign can_up   = ~hold_i && (range_q != RANGE_W'(NUM_RANGES - 1));
  assign can_dn   = ~hold_i && (range_q != '0);
  assign ovf_set  = (state_q == StEval) && over && up_hit && !can_up;
  assign unf_set  = (state_q == StEval) && under && dn_hit && !can_dn;

  always_ff @(posedge clk_i) begin
    if (!clear_ni) state_q <= StIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StRst;
      StRst:    state_d = StGate;
      StGate:   if (cnt_q == '0) state_d = StSettle;
      StSettle: if (cnt_q == '0) state_d = StEval;
      StEval: begin
        if (cont_q)                              state_d = StRst;
        else if (in_range || ovf_set || unf_set) state_d = StIdle;
        else                                     state_d = StRst;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    range_d  = range_q;
    up_cnt_d = up_cnt_q;
    dn_cnt_d = dn_cnt_q;
    cont_d   = cont_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cont_d = cont_i;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
        end
      end
      StRst:    cnt_d = CntW'(GATE_CYCLES - 1);
      StGate:   cnt_d = (cnt_q == '0) ? CntW'(SETTLE_CYCLES - 1) : cnt_q - CntW'(1);
      StSettle: if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      StEval: begin
        if (over) begin
          dn_cnt_d = '0;
          if (up_hit) begin
            // Counter restarts whether the range moved or an error was flagged.
            up_cnt_d = '0;
            if (can_up) range_d = range_q + RANGE_W'(1);
            else        ovf_d   = 1'b1;
          end else begin
            up_cnt_d = up_inc;
          end
        end else if (under) begin
          up_cnt_d = '0;
          if (dn_hit) begin
            dn_cnt_d = '0;
            if (can_dn) range_d = range_q - RANGE_W'(1);
            else        unf_d   = 1'b1;
          end else begin
            dn_cnt_d = dn_inc;
          end
        end else begin
          up_cnt_d = '0;
          dn_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      cnt_q    <= '0;
      range_q  <= RANGE_W'(INIT_RANGE);
      up_cnt_q <= '0;
      dn_cnt_q <= '0;
      cont_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      range_q  <= range_d;
      up_cnt_q <= up_cnt_d;
      dn_cnt_q <= dn_cnt_d;
      cont_q   <= cont_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    reset_o     = (state_q == StRst);
    gate_o      = (state_q == StGate);
    busy_o      = (state_q != StIdle);
    valid_o     = (state_q == StEval) && in_range;
    range_o     = range_q;
    std_f_sel_o = range_q[RANGE_W-1 -: 2];
    ovf_err_o   = ovf_q;
    unf_err_o   = unf_q;
  end

endmodule

// File: tb/tb_freq_autorange_ctrl.sv
// Directed bench for freq_autorange_ctrl with a short gate and hand-computed expectations.
module tb_freq_autorange_ctrl;

  logic       clk_i = 1'b0;
  logic       clear_ni, start_i, cont_i, hold_i, cntover_i, cntlow_i;
  logic       reset_o, gate_o, valid_o, busy_o, ovf_err_o, unf_err_o;
  logic [2:0] range_o;
  logic [1:0] std_f_sel_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  freq_autorange_ctrl #(
    .NUM_RANGES   (8),
    .GATE_CYCLES  (4),
    .SETTLE_CYCLES(2),
    .HYST         (2),
    .INIT_RANGE   (0)
  ) u_dut (
    .clk_i      (clk_i),
    .clear_ni   (clear_ni),
    .start_i    (start_i),
    .cont_i     (cont_i),
    .hold_i     (hold_i),
    .cntover_i  (cntover_i),
    .cntlow_i   (cntlow_i),
    .reset_o    (reset_o),
    .gate_o     (gate_o),
    .range_o    (range_o),
    .std_f_sel_o(std_f_sel_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .ovf_err_o  (ovf_err_o),
    .unf_err_o  (unf_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    clear_ni  = 1'b0;
    start_i   = 1'b0;
    cont_i    = 1'b0;
    hold_i    = 1'b0;
    cntover_i = 1'b0;
    cntlow_i  = 1'b0;
    tick();
    tick();
    clear_ni = 1'b1;
  endtask

  task automatic do_start(input logic cont);
    cont_i  = cont;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cont_i  = 1'b0;
  endtask

  // From RST, seven edges reach EVAL (4 gate + 2 settle + 1).
  task automatic to_eval();
    repeat (7) tick();
  endtask

  task automatic run_evals(input int n);
    for (int k = 0; k < n; k++) begin
      to_eval();
      tick();
    end
  endtask

  initial begin
    do_clear();
    check("rst_busy",  32'(busy_o), 0);
    check("rst_reset", 32'(reset_o), 0);
    check("rst_gate",  32'(gate_o), 0);
    check("rst_range", 32'(range_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_errs",  32'({ovf_err_o, unf_err_o}), 0);

    // Single-shot, in range; a Start pulse mid-gate must be ignored.
    do_start(1'b0);
    check("ss_reset_c1", 32'(reset_o), 1);
    check("ss_gate_c1",  32'(gate_o), 0);
    for (int i = 0; i < 4; i++) begin
      start_i = (i == 1);
      tick();
      start_i = 1'b0;
      check("ss_gate_on", 32'(gate_o), 1);
    end
    tick();
    check("ss_settle_gate", 32'(gate_o), 0);
    check("ss_settle_busy", 32'(busy_o), 1);
    tick();
    check("ss_settle_valid", 32'(valid_o), 0);
    tick();
    check("ss_valid_c8", 32'(valid_o), 1);
    tick();
    check("ss_idle_busy",  32'(busy_o), 0);
    check("ss_idle_valid", 32'(valid_o), 0);
    check("ss_idle_range", 32'(range_o), 0);

    // Single-shot range climb with hysteresis 2.
    do_clear();
    cntover_i = 1'b1;
    do_start(1'b0);
    for (int k = 1; k <= 4; k++) begin
      to_eval();
      check("climb_valid", 32'(valid_o), 0);
      tick();
      check("climb_range", 32'(range_o), (k < 2) ? 0 : ((k < 4) ? 1 : 2));
      check("climb_retry", 32'(busy_o), 1);
    end
    cntover_i = 1'b0;
    to_eval();
    check("climb_final_valid", 32'(valid_o), 1);
    check("climb_final_range", 32'(range_o), 2);
    check("climb_std_f_sel",   32'(std_f_sel_o), 2 >> 1);
    tick();
    check("climb_idle", 32'(busy_o), 0);

    // Continuous mode saturates at the top range and flags overflow.
    do_clear();
    cntover_i = 1'b1;
    do_start(1'b1);
    run_evals(14);
    check("top_range", 32'(range_o), 7);
    check("top_std_f_sel", 32'(std_f_sel_o), 3);
    run_evals(1);
    check("top_ovf_early", 32'(ovf_err_o), 0);
    run_evals(1);
    check("top_ovf", 32'(ovf_err_o), 1);
    check("top_range_held", 32'(range_o), 7);
    check("top_cont_busy", 32'(busy_o), 1);

    do_clear();
    check("clr_ovf", 32'(ovf_err_o), 0);
    cntlow_i = 1'b1;
    do_start(1'b1);
    run_evals(1);
    check("bot_unf_early", 32'(unf_err_o), 0);
    run_evals(1);
    check("bot_unf", 32'(unf_err_o), 1);
    check("bot_range", 32'(range_o), 0);

    // Hold at range 3 turns under-range into an error, then single-shot stops.
    do_clear();
    cntover_i = 1'b1;
    do_start(1'b0);
    run_evals(6);
    check("hold_pre_range", 32'(range_o), 3);
    cntover_i = 1'b0;
    cntlow_i  = 1'b1;
    hold_i    = 1'b1;
    run_evals(1);
    check("hold_range1", 32'(range_o), 3);
    check("hold_unf1",   32'(unf_err_o), 0);
    check("hold_busy1",  32'(busy_o), 1);
    run_evals(1);
    check("hold_range2", 32'(range_o), 3);
    check("hold_unf2",   32'(unf_err_o), 1);
    check("hold_idle",   32'(busy_o), 0);
    hold_i   = 1'b0;
    cntlow_i = 1'b0;

    // Alternating results never move the range; both flags count as over.
    do_clear();
    cntover_i = 1'b1;
    do_start(1'b1);
    for (int k = 0; k < 6; k++) begin
      cntover_i = (k % 2 == 0);
      cntlow_i  = (k % 2 == 1);
      run_evals(1);
      check("alt_range", 32'(range_o), 0);
    end
    cntover_i = 1'b1;
    cntlow_i  = 1'b1;
    run_evals(1);
    check("both_range1", 32'(range_o), 0);
    run_evals(1);
    check("both_range2", 32'(range_o), 1);
    check("both_errs", 32'({ovf_err_o, unf_err_o}), 0);

    // Clear mid-gate at range 5, with a simultaneous Start that must lose.
    do_clear();
    cntover_i = 1'b1;
    do_start(1'b1);
    run_evals(10);
    check("mid_pre_range", 32'(range_o), 5);
    tick();
    check("mid_in_gate", 32'(gate_o), 1);
    tick();
    clear_ni  = 1'b0;
    start_i   = 1'b1;
    tick();
    clear_ni  = 1'b1;
    start_i   = 1'b0;
    cntover_i = 1'b0;
    check("mid_busy",  32'(busy_o), 0);
    check("mid_range", 32'(range_o), 0);
    check("mid_outs",  32'({reset_o, gate_o, valid_o, ovf_err_o, unf_err_o}), 0);
    tick();
    check("mid_start_lost", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
